// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants.
// FETCH_MISALIGN_TRAP_EN adds the trapping halt state to the fetch enum.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_FLUSH
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_IDLE_HALT
`endif
    } fetch_state_t;

    localparam logic [6:0]  OPC_STORE         = 7'b0100011;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage

// File: rtl/imm12_sel.sv
// Opcode-based 12-bit immediate field select (S-type for stores, I-type otherwise).
module imm12_sel
    import cpu_pkg::*;
(
    input  logic [31:0] word,
    output logic [11:0] imm12
);

    always_comb begin
        if (word[6:0] == OPC_STORE) begin
            imm12 = {word[31:25], word[11:7]};
        end else begin
            imm12 = word[31:20];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/ack handshake, instruction register.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of masking them.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [11:0] imm12
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  flush_addr_q, flush_addr_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [11:0]  imm_q, imm_d;
    logic [11:0]  imm_sel;
    logic [31:0]  target;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         misalign_q, misalign_d;
`endif

    imm12_sel u_imm12_sel (
        .word  (imem_rdata),
        .imm12 (imm_sel)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target = branch_target;
`else
    assign target = branch_target & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            flush_addr_q <= RESET_PC;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
            imm_q        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_addr_q <= flush_addr_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            imm_q        <= imm_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_addr_d = flush_addr_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        imm_d        = imm_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (branch_taken) begin
                    // Without the ack the old request is still in flight; remember its address.
                    pc_d = target;
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end else begin
                        flush_addr_d = pc_q;
                        state_d      = ST_FLUSH;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    imm_d   = imm_sel;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (branch_taken || !stall) begin
                    pc_d    = branch_taken ? target : pc_q + 32'd4;
                    instr_d = NOP_INSTR;
                    imm_d   = '0;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                if (branch_taken) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = state_q;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        // A misaligned redirect overrides every other outcome and parks the stage for good.
        if (state_q != ST_IDLE && state_q != ST_IDLE_HALT &&
            branch_taken && branch_target[1:0] != 2'b00) begin
            state_d      = ST_IDLE_HALT;
            pc_d         = pc_q;
            flush_addr_d = flush_addr_q;
            instr_d      = NOP_INSTR;
            imm_d        = '0;
            valid_d      = 1'b0;
            misalign_d   = 1'b1;
        end
`endif
    end

    assign imem_req    = (state_q == ST_REQ) || (state_q == ST_FLUSH);
    assign imem_addr   = (state_q == ST_FLUSH) ? flush_addr_q : pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign imm12       = imm_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign    = misalign_q;
`endif

endmodule
